// File: rtl/command_encoder_pkg.sv
// command_encoder_pkg: opcodes, frame geometry and format decode shared by encoder and control unit
package command_encoder_pkg;

    localparam int CMD_MAX_FRAME_BYTES = 7;
    localparam int BLOCK_INSTR_WIDTH = 32;
    localparam int FRAME_BITS = 8 * CMD_MAX_FRAME_BYTES;

    localparam logic [7:0] CMD_WRITE_BLOCK_INSTR = 8'h10;
    localparam logic [7:0] CMD_WRITE_BLOCK_REG_0 = 8'h11;
    localparam logic [7:0] CMD_WRITE_BLOCK_REG_1 = 8'h12;
    localparam logic [7:0] CMD_UPDATE_BLOCK_REG_0 = 8'h13;
    localparam logic [7:0] CMD_UPDATE_BLOCK_REG_1 = 8'h14;
    localparam logic [7:0] CMD_ALLOC_DELAY = 8'h20;
    localparam logic [7:0] CMD_SET_INPUT_GAIN = 8'h30;
    localparam logic [7:0] CMD_SET_OUTPUT_GAIN = 8'h31;
    localparam logic [7:0] CMD_SWAP_PIPELINES = 8'h40;
    localparam logic [7:0] CMD_RESET_PIPELINE = 8'h41;
    localparam logic [7:0] CMD_COMMIT_REG_UPDATES = 8'h42;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

    typedef enum logic [2:0] {FMT_NONE, FMT_INSTR, FMT_REG, FMT_DELAY, FMT_GAIN, FMT_BARE} frame_fmt_t;

    // Block index needs a second byte once it no longer fits in eight bits
    function automatic int block_bytes(input int n_blocks);
        return (n_blocks > 256) ? 2 : 1;
    endfunction

    function automatic int data_bytes(input int data_width);
        return (data_width == 24) ? 3 : 2;
    endfunction

    function automatic frame_fmt_t cmd_format(input logic [7:0] cmd);
        case (cmd)
            CMD_WRITE_BLOCK_INSTR: return FMT_INSTR;
            CMD_WRITE_BLOCK_REG_0,
            CMD_WRITE_BLOCK_REG_1,
            CMD_UPDATE_BLOCK_REG_0,
            CMD_UPDATE_BLOCK_REG_1: return FMT_REG;
            CMD_ALLOC_DELAY: return FMT_DELAY;
            CMD_SET_INPUT_GAIN,
            CMD_SET_OUTPUT_GAIN: return FMT_GAIN;
            CMD_SWAP_PIPELINES,
            CMD_RESET_PIPELINE,
            CMD_COMMIT_REG_UPDATES: return FMT_BARE;
            default: return FMT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/command_encoder_frame_packer.sv
// command_frame_packer: maps a request onto a left-aligned, MSB-first byte frame and its length
module command_frame_packer
    import command_encoder_pkg::*;
#(
    parameter int n_blocks = 256,
    parameter int data_width = 16
) (
    input  logic [7:0]                   req_command,
    input  logic [$clog2(n_blocks)-1:0]  req_block,
    input  logic [BLOCK_INSTR_WIDTH-1:0] req_instr,
    input  logic [data_width-1:0]        req_data,
    input  logic [23:0]                  req_delay_size,
    input  logic [23:0]                  req_init_delay,
    output logic [FRAME_BITS-1:0]        frame,
    output logic [2:0]                   length,
    output logic                         known
);

    localparam int bb = block_bytes(n_blocks);
    localparam int db = data_bytes(data_width);
    localparam logic [FRAME_BITS-1:0] data_mask = (FRAME_BITS'(1) << (8 * db)) - FRAME_BITS'(1);

    logic [FRAME_BITS-1:0] head;
    logic [FRAME_BITS-1:0] blk;
    logic [FRAME_BITS-1:0] dat;
    frame_fmt_t fmt;

    // Opcode always leads; following fields are shifted into place just below it
    always_comb begin
        fmt = cmd_format(req_command);
        head = {req_command, {(FRAME_BITS - 8){1'b0}}};
        blk = FRAME_BITS'(req_block);
        dat = FRAME_BITS'(req_data) & data_mask;
        frame = '0;
        length = 3'd0;
        known = 1'b1;
        case (fmt)
            FMT_INSTR: begin
                frame = head | (blk << (48 - 8 * bb)) | (FRAME_BITS'(req_instr) << (16 - 8 * bb));
                length = 3'(5 + bb);
            end
            FMT_REG: begin
                frame = head | (blk << (48 - 8 * bb)) | (dat << (48 - 8 * bb - 8 * db));
                length = 3'(1 + bb + db);
            end
            FMT_DELAY: begin
                frame = {req_command, req_delay_size, req_init_delay};
                length = 3'd7;
            end
            FMT_GAIN: begin
                frame = head | (dat << (48 - 8 * db));
                length = 3'(1 + db);
            end
            FMT_BARE: begin
                frame = head;
                length = 3'd1;
            end
            default: known = 1'b0;
        endcase
    end

endmodule

// File: rtl/command_encoder.sv
// command_encoder: serialises host command requests into control-unit byte frames over valid/next
module command_encoder
    import command_encoder_pkg::*;
#(
    parameter int n_blocks = 256,
    parameter int data_width = 16,
    parameter int timeout_cycles = 65535
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [7:0]                   req_command,
    input  logic [$clog2(n_blocks)-1:0]  req_block,
    input  logic [BLOCK_INSTR_WIDTH-1:0] req_instr,
    input  logic [data_width-1:0]        req_data,
    input  logic [23:0]                  req_delay_size,
    input  logic [23:0]                  req_init_delay,
    output logic [7:0]                   out_byte,
    output logic                         out_valid,
    input  logic                         out_next,
    output logic                         done,
    output logic                         timeout,
    output logic                         invalid,
    output logic                         busy,
    output logic [15:0]                  bytes_sent
);

    localparam int tw = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    localparam logic [tw-1:0] to_last = tw'(timeout_cycles - 1);

    state_t state;
    logic [FRAME_BITS-1:0] frame;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [2:0] length;
    logic [2:0] remaining;
    logic known;
    logic [tw-1:0] wait_cnt;

    command_frame_packer #(
        .n_blocks(n_blocks),
        .data_width(data_width)
    ) packer (
        .req_command(req_command),
        .req_block(req_block),
        .req_instr(req_instr),
        .req_data(req_data),
        .req_delay_size(req_delay_size),
        .req_init_delay(req_init_delay),
        .frame(frame),
        .length(length),
        .known(known)
    );

    // Frame FSM: accept in IDLE, hand bytes out on each out_next, one GAP cycle after a full frame
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            shift_reg <= '0;
            remaining <= 3'd0;
            wait_cnt <= '0;
            req_ready <= 1'b0;
            out_byte <= 8'd0;
            out_valid <= 1'b0;
            done <= 1'b0;
            timeout <= 1'b0;
            invalid <= 1'b0;
            busy <= 1'b0;
            bytes_sent <= 16'd0;
        end else begin
            done <= 1'b0;
            timeout <= 1'b0;
            invalid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        if (known) begin
                            state <= ST_SEND;
                            shift_reg <= frame;
                            remaining <= length;
                            out_byte <= frame[FRAME_BITS-1 -: 8];
                            out_valid <= 1'b1;
                            busy <= 1'b1;
                            req_ready <= 1'b0;
                            wait_cnt <= '0;
                        end else begin
                            invalid <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (out_next) begin
                        bytes_sent <= bytes_sent + 16'd1;
                        shift_reg <= shift_reg << 8;
                        remaining <= remaining - 3'd1;
                        wait_cnt <= '0;
                        if (remaining == 3'd1) begin
                            out_valid <= 1'b0;
                            done <= 1'b1;
                            state <= ST_GAP;
                        end else begin
                            out_byte <= shift_reg[FRAME_BITS-9 -: 8];
                        end
                    end else if (timeout_cycles != 0 && wait_cnt == to_last) begin
                        out_valid <= 1'b0;
                        timeout <= 1'b1;
                        busy <= 1'b0;
                        req_ready <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                    busy <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_command_encoder.sv
// tb_command_encoder: directed and random frames checked against a byte-queue model of the frame rules
module tb_command_encoder;
    import command_encoder_pkg::*;

    localparam int BB = (256 > 256) ? 2 : 1;
    localparam int DB = (16 == 24) ? 3 : 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, req_valid, req_ready, out_valid, out_next, done, timeout, invalid, busy;
    logic [7:0] req_command, req_block, out_byte;
    logic [31:0] req_instr;
    logic [15:0] req_data, bytes_sent;
    logic [23:0] req_delay_size, req_init_delay;

    logic t_valid, t_ready, t_ovalid, t_next, t_done, t_timeout, t_invalid, t_busy;
    logic [7:0] t_byte;
    logic [15:0] t_sent;

    command_encoder dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_command(req_command), .req_block(req_block), .req_instr(req_instr),
        .req_data(req_data), .req_delay_size(req_delay_size), .req_init_delay(req_init_delay),
        .out_byte(out_byte), .out_valid(out_valid), .out_next(out_next), .done(done),
        .timeout(timeout), .invalid(invalid), .busy(busy), .bytes_sent(bytes_sent)
    );

    command_encoder #(.timeout_cycles(16)) dut_to (
        .clk(clk), .reset(reset), .req_valid(t_valid), .req_ready(t_ready),
        .req_command(req_command), .req_block(req_block), .req_instr(req_instr),
        .req_data(req_data), .req_delay_size(req_delay_size), .req_init_delay(req_init_delay),
        .out_byte(t_byte), .out_valid(t_ovalid), .out_next(t_next), .done(t_done),
        .timeout(t_timeout), .invalid(t_invalid), .busy(t_busy), .bytes_sent(t_sent)
    );

    int n_checks = 0;
    int n_fail = 0;
    int sent = 0;
    logic [7:0] exp_q[$];
    bit exp_known;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_be(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[8*i +: 8]);
    endtask

    task automatic model(input logic [7:0] cmd, input logic [7:0] blk, input logic [31:0] instr,
                         input logic [15:0] data, input logic [23:0] sz, input logic [23:0] init);
        exp_q.delete();
        exp_known = 1'b1;
        exp_q.push_back(cmd);
        if (cmd == CMD_WRITE_BLOCK_INSTR) begin
            push_be(32'(blk), BB);
            push_be(instr, 4);
        end else if (cmd inside {CMD_WRITE_BLOCK_REG_0, CMD_WRITE_BLOCK_REG_1,
                                 CMD_UPDATE_BLOCK_REG_0, CMD_UPDATE_BLOCK_REG_1}) begin
            push_be(32'(blk), BB);
            push_be(32'(data), DB);
        end else if (cmd == CMD_ALLOC_DELAY) begin
            push_be(32'(sz), 3);
            push_be(32'(init), 3);
        end else if (cmd inside {CMD_SET_INPUT_GAIN, CMD_SET_OUTPUT_GAIN}) begin
            push_be(32'(data), DB);
        end else if (!(cmd inside {CMD_SWAP_PIPELINES, CMD_RESET_PIPELINE, CMD_COMMIT_REG_UPDATES})) begin
            exp_known = 1'b0;
            exp_q.delete();
        end
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] blk, input logic [31:0] instr,
                             input logic [15:0] data, input logic [23:0] sz, input logic [23:0] init,
                             input int hold, input string tag);
        model(cmd, blk, instr, data, sz, init);
        @(negedge clk);
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_command = cmd;
        req_block = blk;
        req_instr = instr;
        req_data = data;
        req_delay_size = sz;
        req_init_delay = init;
        @(negedge clk);
        req_valid = 1'b0;
        if (!exp_known) begin
            chk({tag, " invalid"}, 32'(invalid), 32'd1);
            chk({tag, " no valid"}, 32'(out_valid), 32'd0);
            chk({tag, " ready kept"}, 32'(req_ready), 32'd1);
            return;
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            for (int h = 0; h <= hold; h++) begin
                chk({tag, " valid"}, 32'(out_valid), 32'd1);
                chk({tag, " byte"}, 32'(out_byte), 32'(exp_q[i]));
                chk({tag, " no done"}, 32'(done), 32'd0);
                chk({tag, " no timeout"}, 32'(timeout), 32'd0);
                if (h < hold) @(negedge clk);
            end
            out_next = 1'b1;
            @(negedge clk);
            out_next = 1'b0;
        end
        sent += exp_q.size();
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " gap valid"}, 32'(out_valid), 32'd0);
        chk({tag, " gap busy"}, 32'(busy), 32'd1);
        chk({tag, " gap ready"}, 32'(req_ready), 32'd0);
        chk({tag, " bytes_sent"}, 32'(bytes_sent), 32'(sent[15:0]));
    endtask

    logic [7:0] cmd_tbl[11] = '{CMD_WRITE_BLOCK_INSTR, CMD_WRITE_BLOCK_REG_0, CMD_WRITE_BLOCK_REG_1,
                                CMD_UPDATE_BLOCK_REG_0, CMD_UPDATE_BLOCK_REG_1, CMD_ALLOC_DELAY,
                                CMD_SET_INPUT_GAIN, CMD_SET_OUTPUT_GAIN, CMD_SWAP_PIPELINES,
                                CMD_RESET_PIPELINE, CMD_COMMIT_REG_UPDATES};

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        out_next = 1'b0;
        t_valid = 1'b0;
        t_next = 1'b0;
        req_command = 8'd0;
        req_block = 8'd0;
        req_instr = 32'd0;
        req_data = 16'd0;
        req_delay_size = 24'd0;
        req_init_delay = 24'd0;
        repeat (2) @(negedge clk);
        chk("reset ready", 32'(req_ready), 32'd0);
        chk("reset valid", 32'(out_valid), 32'd0);
        chk("reset byte", 32'(out_byte), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset pulses", {29'd0, done, timeout, invalid}, 32'd0);
        chk("reset count", 32'(bytes_sent), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post reset ready", 32'(req_ready), 32'd1);

        run_frame(CMD_WRITE_BLOCK_INSTR, 8'h12, 32'hDEADBEEF, 16'h0, 24'h0, 24'h0, 1, "instr");
        chk("instr count 6", 32'(bytes_sent), 32'd6);
        run_frame(CMD_WRITE_BLOCK_REG_1, 8'h05, 32'h0, 16'hA55A, 24'h0, 24'h0, 1, "reg1");
        run_frame(CMD_SET_INPUT_GAIN, 8'h00, 32'h0, 16'h1234, 24'h0, 24'h0, 0, "b2b gain");
        run_frame(CMD_ALLOC_DELAY, 8'h00, 32'h0, 16'h0, 24'h001000, 24'h000800, 0, "alloc");
        run_frame(CMD_SWAP_PIPELINES, 8'h00, 32'h0, 16'h0, 24'h0, 24'h0, 50, "swap hold");

        @(negedge clk);
        req_command = CMD_SWAP_PIPELINES;
        t_valid = 1'b1;
        @(negedge clk);
        t_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            chk("to valid", 32'(t_ovalid), 32'd1);
            chk("to early", 32'(t_timeout), 32'd0);
            if (k < 16) @(negedge clk);
        end
        @(negedge clk);
        chk("to pulse", 32'(t_timeout), 32'd1);
        chk("to valid drop", 32'(t_ovalid), 32'd0);
        @(negedge clk);
        chk("to ready", 32'(t_ready), 32'd1);
        chk("to pulse end", 32'(t_timeout), 32'd0);
        chk("to no done", 32'(t_done), 32'd0);

        run_frame(8'hFF, 8'h00, 32'h0, 16'h0, 24'h0, 24'h0, 0, "bad op");
        @(negedge clk);
        chk("bad op pulse end", 32'(invalid), 32'd0);
        chk("bad op count", 32'(bytes_sent), 32'(sent[15:0]));

        repeat (20) begin
            int idx;
            idx = $urandom_range(0, 11);
            run_frame((idx < 11) ? cmd_tbl[idx] : 8'($urandom), 8'($urandom), $urandom,
                      16'($urandom), 24'($urandom), 24'($urandom), $urandom_range(0, 3), "rand");
        end

        @(negedge clk);
        model(CMD_WRITE_BLOCK_INSTR, 8'h77, 32'h01020304, 16'h0, 24'h0, 24'h0);
        req_command = CMD_WRITE_BLOCK_INSTR;
        req_block = 8'h77;
        req_instr = 32'h01020304;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        out_next = 1'b1;
        @(negedge clk);
        chk("mid byte 2", 32'(out_byte), 32'(exp_q[1]));
        @(negedge clk);
        out_next = 1'b0;
        chk("mid count", 32'(bytes_sent), 32'((sent + 2) & 16'hFFFF));
        reset = 1'b1;
        @(negedge clk);
        sent = 0;
        chk("mid rst valid", 32'(out_valid), 32'd0);
        chk("mid rst count", 32'(bytes_sent), 32'd0);
        chk("mid rst done", 32'(done), 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid rst ready", 32'(req_ready), 32'd1);
        chk("mid rst no done", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
